bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
Parametrised shared-bus driver for the 8-bit computer. Replaces the single-source two-way bus mux with N one-hot-enabled sources (RAM, IR, A, ALU, PC, ...).
- Zero-latency priority selection onto the bus.
- Optional bus keeper that holds the last driven value when the bus is idle.
- Registered contention detection: sticky fault state, first-fault source capture and a saturating event counter for debug and verification.

Parameters:
WIDTH, 8, bus data width in bits
N_SRC, 5, number of bus sources (minimum 2)
KEEP, 1, 1 = idle bus holds the last driven value; 0 = idle bus passes bus_in
CNT_W, 8, width of the contention event counter
IDX_W (localparam), $clog2(N_SRC), width of the source index

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
bus_in  in  WIDTH  default bus value when idle and KEEP=0
src_data  in  N_SRC*WIDTH  source data; source i occupies bits [i*WIDTH +: WIDTH]
src_oe  in  N_SRC  per-source output enable (RO, IO, AO, EO, CO, ...)
err_clear  in  1  single-cycle pulse; clears the fault state
bus_out  out  WIDTH  current bus value (combinational)
bus_busy  out  1  combinational: any src_oe bit asserted
contention  out  1  combinational: more than one src_oe bit asserted
last_idx  out  IDX_W  registered index of the last source that won the bus
fault  out  1  registered sticky contention flag (state == FAULT)
fault_mask  out  N_SRC  src_oe snapshot taken at the first contention since the last clear
err_count  out  CNT_W  saturating count of contention cycles

Behaviour:
- Selection (combinational, zero latency):
  - The winner is the lowest asserted index in src_oe.
  - bus_out = src_data[winner] in the same cycle.
  - With no src_oe bit asserted: bus_out = keeper register if KEEP=1, otherwise bus_in.
- Keeper register (WIDTH bits):
  - On every rising edge with bus_busy=1, keeper <= selected data.
  - Otherwise it holds its value.
  - Reset value is 0.
- last_idx updates on the same edges as the keeper and takes the winner index. It holds while idle. Reset value is 0.
- contention = popcount(src_oe) > 1. A single asserted bit or no asserted bits is legal.
- State machine (2 states), state register reset to IDLE_OK:
  - IDLE_OK -> FAULT on an edge with contention=1 and err_clear=0.
  - IDLE_OK with contention=1 and err_clear=1 -> FAULT (the set wins).
  - FAULT -> IDLE_OK on an edge with err_clear=1 and contention=0.
  - FAULT with err_clear=1 and contention=1 -> stays in FAULT, and the event is treated as a new first contention.
  - fault = (state == FAULT).
- fault_mask:
  - Loaded with src_oe on any edge where contention=1 and either state==IDLE_OK or err_clear=1.
  - Otherwise it holds.
  - Cleared to 0 on reset, and on an err_clear edge with no contention.
- err_count:
  - Increments by 1 on each edge with contention=1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - err_clear without contention sets it to 0.
  - err_clear with contention on the same edge sets it to 1.
  - Reset value is 0.
- Contention does not change selection: the priority winner still drives bus_out, and the keeper and last_idx update normally.
- Reset:
  - All registers clear on the first edge with reset=1, with priority over every other input.
  - Reset asserted mid-fault returns the state to IDLE_OK.
  - During reset, bus_out stays combinational from src_oe/src_data. When idle, bus_out shows the keeper, which reads 0 once reset has been sampled.
- No X propagation: with all src_oe bits at 0, bus_out never depends on src_data.

Test Plan:
- Reset, then idle with KEEP=1 and bus_in=8'hAA -> bus_out=8'h00, fault=0, err_count=0, last_idx=0.
- src_oe=5'b00100 with src_data[2]=8'h3C for 1 cycle, then src_oe=0 -> bus_out=8'h3C in the driven cycle and stays 8'h3C while idle (KEEP=1); last_idx=2. With KEEP=0, bus_out=bus_in=8'hAA when idle.
- src_oe=5'b01010 (sources 1 and 3, data 8'h11 and 8'h33) for 3 cycles -> contention=1 and bus_out=8'h11 each cycle; after the first edge fault=1 and fault_mask=5'b01010; err_count=3 after the third edge.
- In FAULT, a second contention with src_oe=5'b10001 -> fault_mask stays 5'b01010 and err_count increments. err_clear with no contention -> fault=0, fault_mask=0, err_count=0 on the next edge.
- err_clear coincident with contention on src_oe=5'b00011 -> fault=1, fault_mask=5'b00011, err_count=1.
- CNT_W=2 with 5 contention cycles -> err_count saturates at 3. Reset asserted while fault=1 -> all registered outputs 0 after one edge.

Source files
------------

// File: rtl/bus_arbiter.sv
// Shared-bus driver: lowest-index one-hot source wins the bus with zero latency.
// An optional keeper holds the last value while idle; contention is logged in sticky debug registers.
module bus_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int N_SRC = 5,
  parameter  int KEEP  = 1,
  parameter  int CNT_W = 8,
  localparam int IDX_W = $clog2(N_SRC)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [WIDTH-1:0]       i_bus_in,
  input  logic [N_SRC*WIDTH-1:0] i_src_data,
  input  logic [N_SRC-1:0]       i_src_oe,
  input  logic                   i_err_clear,
  output logic [WIDTH-1:0]       o_bus_out,
  output logic                   o_bus_busy,
  output logic                   o_contention,
  output logic [IDX_W-1:0]       o_last_idx,
  output logic                   o_fault,
  output logic [N_SRC-1:0]       o_fault_mask,
  output logic [CNT_W-1:0]       o_err_count
);

  typedef enum logic {
    IDLE_OK = 1'b0,
    FAULT   = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_keep;
  logic [IDX_W-1:0] r_last_idx;
  logic [N_SRC-1:0] r_fault_mask;
  logic [CNT_W-1:0] r_err_count;

  logic [IDX_W-1:0] w_idx;
  logic [WIDTH-1:0] w_sel;
  logic             w_busy;
  logic             w_cont;
  logic             w_first;

  // Priority select: scan high to low so the lowest asserted index is written last.
  always_comb begin
    w_idx = '0;
    w_sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      w_idx = i_src_oe[i] ? IDX_W'(i) : w_idx;
      w_sel = i_src_oe[i] ? i_src_data[i*WIDTH +: WIDTH] : w_sel;
    end
  end

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign w_busy = |i_src_oe;
  assign w_cont = |(i_src_oe & (i_src_oe - N_SRC'(1)));

  assign o_bus_out = w_busy ? w_sel : ((KEEP != 0) ? r_keep : i_bus_in);

  // Fault state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE_OK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a clear that coincides with contention counts as a fresh first fault.
  always_comb begin
    w_state_nxt = r_state;
    w_first     = 1'b0;
    case (r_state)
      IDLE_OK: begin
        w_first = w_cont;
        if (w_cont) begin
          w_state_nxt = FAULT;
        end else begin
          w_state_nxt = IDLE_OK;
        end
      end
      FAULT: begin
        w_first = w_cont & i_err_clear;
        if (i_err_clear && !w_cont) begin
          w_state_nxt = IDLE_OK;
        end else begin
          w_state_nxt = FAULT;
        end
      end
      default: begin
        w_state_nxt = IDLE_OK;
        w_first     = 1'b0;
      end
    endcase
  end

  // Keeper, winner index, first-fault snapshot and saturating contention counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_keep       <= '0;
      r_last_idx   <= '0;
      r_fault_mask <= '0;
      r_err_count  <= '0;
    end else begin
      if (w_busy) begin
        r_keep     <= w_sel;
        r_last_idx <= w_idx;
      end
      if (w_first) begin
        r_fault_mask <= i_src_oe;
      end else if (i_err_clear) begin
        r_fault_mask <= '0;
      end
      if (i_err_clear) begin
        r_err_count <= w_cont ? CNT_W'(1) : '0;
      end else if (w_cont && (r_err_count != CNT_MAX)) begin
        r_err_count <= r_err_count + CNT_W'(1);
      end
    end
  end

  assign o_bus_busy   = w_busy;
  assign o_contention = w_cont;
  assign o_last_idx   = r_last_idx;
  assign o_fault      = (r_state == FAULT);
  assign o_fault_mask = r_fault_mask;
  assign o_err_count  = r_err_count;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: one keeper/8-bit-counter instance and one pass-through/2-bit-counter instance.
module tb_bus_arbiter;

  localparam logic [39:0] DATA = {8'hC4, 8'h33, 8'h3C, 8'h11, 8'hA0};

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  bus_in;
  logic [39:0] src_data;
  logic [4:0]  src_oe;
  logic        err_clear;

  logic [7:0] a_bus, b_bus;
  logic       a_busy, b_busy, a_cont, b_cont, a_fault, b_fault;
  logic [2:0] a_idx, b_idx;
  logic [4:0] a_mask, b_mask;
  logic [7:0] a_cnt;
  logic [1:0] b_cnt;

  typedef struct {
    logic [7:0] bus_a;
    logic [7:0] bus_b;
    logic       busy;
    logic       cont;
  } comb_exp_t;

  typedef struct {
    logic [2:0] idx;
    logic       fault;
    logic [4:0] mask;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
  } reg_exp_t;

  comb_exp_t comb_q[$];
  reg_exp_t  reg_q[$];

  logic [7:0] m_keep;
  logic [2:0] m_idx;
  logic       m_fault;
  logic [4:0] m_mask;
  logic [7:0] m_cnt_a;
  logic [1:0] m_cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.WIDTH(8), .N_SRC(5), .KEEP(1), .CNT_W(8)) dut_a (
    .i_clk(clk), .i_reset(reset), .i_bus_in(bus_in), .i_src_data(src_data),
    .i_src_oe(src_oe), .i_err_clear(err_clear), .o_bus_out(a_bus),
    .o_bus_busy(a_busy), .o_contention(a_cont), .o_last_idx(a_idx),
    .o_fault(a_fault), .o_fault_mask(a_mask), .o_err_count(a_cnt)
  );

  bus_arbiter #(.WIDTH(8), .N_SRC(5), .KEEP(0), .CNT_W(2)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_bus_in(bus_in), .i_src_data(src_data),
    .i_src_oe(src_oe), .i_err_clear(err_clear), .o_bus_out(b_bus),
    .o_bus_busy(b_busy), .o_contention(b_cont), .o_last_idx(b_idx),
    .o_fault(b_fault), .o_fault_mask(b_mask), .o_err_count(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int low_idx(input logic [4:0] oe);
    for (int i = 0; i < 5; i++) begin
      if (oe[i]) return i;
    end
    return -1;
  endfunction

  // Drive one cycle starting just after a rising edge; check combinational outputs, then registered ones after the edge.
  task automatic step(input logic [4:0] oe, input logic clr, input logic rst, input bit do_comb);
    comb_exp_t ce;
    reg_exp_t  re;
    int        w;
    logic [7:0] sel;
    logic       cont;

    src_oe    = oe;
    err_clear = clr;
    reset     = rst;
    if (oe == 5'b00000) src_data = {$urandom(), 8'($urandom())};
    else                src_data = DATA;

    w    = low_idx(oe);
    sel  = (w >= 0) ? src_data[w*8 +: 8] : 8'h00;
    cont = ($countones(oe) > 1);
    ce.bus_a = (w >= 0) ? sel : m_keep;
    ce.bus_b = (w >= 0) ? sel : bus_in;
    ce.busy  = (oe != 5'b00000);
    ce.cont  = cont;
    if (do_comb) comb_q.push_back(ce);

    if (rst) begin
      m_keep = 8'h00; m_idx = 3'd0; m_fault = 1'b0; m_mask = 5'b00000;
      m_cnt_a = 8'h00; m_cnt_b = 2'd0;
    end else begin
      if (w >= 0) begin
        m_keep = sel;
        m_idx  = 3'(w);
      end
      if (cont && (!m_fault || clr)) m_mask = oe;
      else if (clr)                  m_mask = 5'b00000;
      if (cont)     m_fault = 1'b1;
      else if (clr) m_fault = 1'b0;
      if (clr) begin
        m_cnt_a = cont ? 8'd1 : 8'd0;
        m_cnt_b = cont ? 2'd1 : 2'd0;
      end else if (cont) begin
        if (m_cnt_a != 8'hFF) m_cnt_a = m_cnt_a + 8'd1;
        if (m_cnt_b != 2'd3)  m_cnt_b = m_cnt_b + 2'd1;
      end
    end
    re.idx = m_idx; re.fault = m_fault; re.mask = m_mask;
    re.cnt_a = m_cnt_a; re.cnt_b = m_cnt_b;
    reg_q.push_back(re);

    #1;
    if (do_comb) begin
      ce = comb_q.pop_front();
      check("bus_out_keep", 32'(a_bus), 32'(ce.bus_a));
      check("bus_out_pass", 32'(b_bus), 32'(ce.bus_b));
      check("bus_busy", 32'(a_busy), 32'(ce.busy));
      check("contention", 32'(a_cont), 32'(ce.cont));
      check("contention_b", 32'(b_cont), 32'(ce.cont));
    end

    @(posedge clk);
    #1;
    re = reg_q.pop_front();
    check("last_idx", 32'(a_idx), 32'(re.idx));
    check("last_idx_b", 32'(b_idx), 32'(re.idx));
    check("fault", 32'(a_fault), 32'(re.fault));
    check("fault_b", 32'(b_fault), 32'(re.fault));
    check("fault_mask", 32'(a_mask), 32'(re.mask));
    check("fault_mask_b", 32'(b_mask), 32'(re.mask));
    check("err_count", 32'(a_cnt), 32'(re.cnt_a));
    check("err_count_sat", 32'(b_cnt), 32'(re.cnt_b));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    m_keep = 8'h00; m_idx = 3'd0; m_fault = 1'b0; m_mask = 5'b00000;
    m_cnt_a = 8'h00; m_cnt_b = 2'd0;
    reset = 1'b1; bus_in = 8'hAA; src_data = DATA; src_oe = 5'b00000; err_clear = 1'b0;
    #1;
    step(5'b00000, 1'b0, 1'b1, 1'b0);
    step(5'b00000, 1'b0, 1'b1, 1'b1);
    step(5'b00000, 1'b0, 1'b0, 1'b1);
    // single driver then idle: keeper holds 3C, pass-through shows AA
    step(5'b00100, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(5'b00000, 1'b0, 1'b0, 1'b1);
    // contention between sources 1 and 3
    for (int i = 0; i < 3; i++) step(5'b01010, 1'b0, 1'b0, 1'b1);
    step(5'b10001, 1'b0, 1'b0, 1'b1);
    step(5'b00000, 1'b1, 1'b0, 1'b1);
    step(5'b00000, 1'b0, 1'b0, 1'b1);
    step(5'b00011, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(5'b11000, 1'b0, 1'b0, 1'b1);
    step(5'b10000, 1'b0, 1'b0, 1'b1);
    // reset mid-fault
    step(5'b00110, 1'b0, 1'b1, 1'b1);
    step(5'b00000, 1'b0, 1'b0, 1'b1);
    bus_in = 8'h5C;
    for (int i = 0; i < 60; i++) begin
      step(5'($urandom()), ($urandom_range(0, 5) == 0), ($urandom_range(0, 40) == 0), 1'b1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
